ascon_init: RTL and testbench
=============================

Name: ascon_init

Overview:
- Upstream initialization stage for the ASCON-128 datapath; produces the 320-bit state that feeds the associated-data stage.
- On start it latches key and nonce and loads IV||K||N.
- It then runs the 12-round permutation p^a, one round per clock, and XORs the key into the last 128 bits.
- It presents the result on ini_sout with a one-cycle done pulse; encrypt and decrypt paths share one instance type.

Parameters:
- ROUNDS, 12, number of permutation rounds (p^a); legal range 1..12. Uses the last ROUNDS constants of the 12-entry table.
- IV, 64'h80400c0600000000, ASCON-128 initialization vector.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- key  in  128  K, sampled on the accepting edge.
- nonce  in  128  N, sampled on the accepting edge.
- busy  out  1  high while rounds are in progress.
- done  out  1  one-cycle pulse when ini_sout is updated.
- ini_sout  out  320  initialized state: x0=[319:256], x1=[255:192], x2=[191:128], x3=[127:64], x4=[63:0].

Behaviour:
- Reset: while rst=1 at an edge, the following clear to 0: FSM=IDLE, round counter, working state, latched key, busy, done, ini_sout. Reset mid-RUN aborts with no done pulse and ini_sout=0.
- FSM states:
  - IDLE: start=1 at an edge does the following:
    - loads x0=IV, x1=key[127:64], x2=key[63:0], x3=nonce[127:64], x4=nonce[63:0];
    - latches the key;
    - sets rnd=12-ROUNDS, busy=1, FSM=RUN.
  - RUN: each edge applies one round with constant RC[rnd], then rnd++.
  - Completion: on the edge where rnd==11:
    - ini_sout <= round_result with x3^=Klatched[127:64] and x4^=Klatched[63:0];
    - done <= 1, busy <= 0, FSM=IDLE.
- Latency: start accepted at edge E produces done=1 and a valid ini_sout in the cycle after edge E+ROUNDS. That is 12 cycles for the default.
- Throughput: start may be high in the same cycle as done; it is accepted, giving back-to-back operation with period ROUNDS.
- start while busy=1 is ignored, not queued. key and nonce changes after acceptance have no effect.
- done is high for exactly one cycle per completed operation. ini_sout holds its value until the next completion or reset.
- Round function, in order:
  - Constant addition: x2 ^= {56'b0, RC[rnd]}, with RC = f0,e1,d2,c3,b4,a5,96,87,78,69,5a,4b.
  - S-box: applied on each bit column i, with the 5-bit index {x0[i],x1[i],x2[i],x3[i],x4[i]} (x0 = MSB). Table is 04,0b,1f,14,1a,15,09,02,1b,05,08,12,1d,03,06,1c,1e,13,07,0e,00,0d,11,18,10,0c,01,19,16,0a,0f,17. Bitsliced equivalent allowed.
  - Linear layer: x0^=ror19^ror28; x1^=ror61^ror39; x2^=ror1^ror6; x3^=ror10^ror17; x4^=ror7^ror41. All rotations are 64-bit rotate-right of the word's own pre-layer value.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package ascon_pkg contains:
  - IV constant;
  - 12-entry round-constant array;
  - S-box table;
  - state word slice index constants (X0..X4 ranges).
- Sub-module ascon_round: purely combinational.
  - Ports: state_in[319:0], rc[7:0], state_out[319:0].
  - Reused later by the AD, CT and finalization stages.
- ascon_init holds only the FSM, counter, registers and final key XOR.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then start=0 for 20 cycles -> busy=0, done=0, ini_sout=0 throughout.
- Known answer: key=nonce=000102…0f, start pulse -> busy=1 for 12 cycles, done=1 exactly 12 cycles after the accepting edge. ini_sout bit-matches the C reference init, and feeding it through AD/CT/finalization with empty AD/PT gives tag e355159f292911f794cb1432a0103a8a.
- Start while busy: second start with a different nonce at cycle +5 -> ignored; single done; result equals the first-nonce golden value.
- Back-to-back: start held high for 30 cycles with nonce changing each cycle -> done at +12 and +24. Each result matches the nonce present on its accepting edge.
- Input hold: key/nonce toggled randomly after acceptance -> ini_sout equals the value golden-modelled from the inputs at acceptance.
- Reset mid-operation: rst=1 at round 6 -> no done; ini_sout=0, busy=0. A new start completes correctly in 12 cycles.

Source files
------------

// File: rtl/ascon_pkg.sv
// ascon_pkg: shared ASCON constants, state-word offsets and rotate helper
package ascon_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [63:0] ASCON_IV = 64'h80400c0600000000;
  localparam int X0 = 256;
  localparam int X1 = 192;
  localparam int X2 = 128;
  localparam int X3 = 64;
  localparam int X4 = 0;
  localparam logic [7:0] RC [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction
endpackage

// File: rtl/ascon_init_if.sv
// ascon_init_if: start/key/nonce request and initialized-state response bundle
interface ascon_init_if;
  logic         start;
  logic [127:0] key;
  logic [127:0] nonce;
  logic         busy;
  logic         done;
  logic [319:0] ini_sout;
  modport master (output start, key, nonce, input busy, done, ini_sout);
  modport slave  (input start, key, nonce, output busy, done, ini_sout);
endinterface

// File: rtl/ascon_round.sv
// ascon_round: one combinational ASCON permutation round (constant, S-box, linear layer)
module ascon_round
  import ascon_pkg::*;
(
  input  logic [319:0] state_in,
  input  logic [7:0]   rc,
  output logic [319:0] state_out
);
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] s0, s1, s2, s3, s4;
  assign a0 = state_in[X0+:64];
  assign a1 = state_in[X1+:64];
  assign a2 = state_in[X2+:64] ^ {56'b0, rc};
  assign a3 = state_in[X3+:64];
  assign a4 = state_in[X4+:64];
  for (genvar i = 0; i < 64; i++) begin : g_col
    assign {s0[i], s1[i], s2[i], s3[i], s4[i]} = SBOX[{a0[i], a1[i], a2[i], a3[i], a4[i]}];
  end
  assign state_out[X0+:64] = s0 ^ ror(s0, 19) ^ ror(s0, 28);
  assign state_out[X1+:64] = s1 ^ ror(s1, 61) ^ ror(s1, 39);
  assign state_out[X2+:64] = s2 ^ ror(s2, 1)  ^ ror(s2, 6);
  assign state_out[X3+:64] = s3 ^ ror(s3, 10) ^ ror(s3, 17);
  assign state_out[X4+:64] = s4 ^ ror(s4, 7)  ^ ror(s4, 41);
endmodule

// File: rtl/ascon_init.sv
// ascon_init: loads IV||K||N, runs p^a one round per clock, XORs key into the tail
module ascon_init
  import ascon_pkg::*;
#(
  parameter int          ROUNDS = 12,
  parameter logic [63:0] IV     = ASCON_IV
) (
  input  logic        clk,
  input  logic        rst,
  ascon_init_if.slave bus
);
  localparam logic [3:0] RND0 = 4'(12 - ROUNDS);
  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [319:0] x_q, x_d, sout_q, sout_d, round_out;
  logic [127:0] key_q, key_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic         run, last, load;
  ascon_round u_round (
    .state_in  (x_q),
    .rc        (RC[rnd_q]),
    .state_out (round_out)
  );
  assign run  = state_q == RUN;
  assign last = run && rnd_q == 4'd11;
  // the completing edge also accepts a new start, giving a period of ROUNDS
  assign load = bus.start && (!run || last);
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
  end
  always_comb begin
    state_d = load ? RUN : last ? IDLE : state_q;
  end
  always_comb begin
    x_d    = load ? {IV, bus.key, bus.nonce} : run ? round_out : x_q;
    key_d  = load ? bus.key : key_q;
    rnd_d  = load ? RND0 : (run && !last) ? rnd_q + 4'd1 : rnd_q;
    busy_d = state_d == RUN;
    done_d = last;
    sout_d = last ? round_out ^ {192'b0, key_q} : sout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_q  <= '0;
      x_q    <= '0;
      key_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sout_q <= '0;
    end else begin
      rnd_q  <= rnd_d;
      x_q    <= x_d;
      key_q  <= key_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sout_q <= sout_d;
    end
  end
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ini_sout = sout_q;
endmodule

// File: tb/tb_ascon_init.sv
// tb_ascon_init: randomized scoreboard bench against a word-array ASCON init model
module tb_ascon_init;
  localparam int R = 12;
  localparam logic [4:0] SB [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  logic clk = 1'b0;
  logic rst = 1'b1;
  ascon_init_if bus ();
  ascon_init #(.ROUNDS(R)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [319:0] exp_q [$];
  logic [319:0] last_sout = '0;
  int   rem = 0;
  bit   exp_busy = 0, exp_done = 0, rst_edge = 0;

  function automatic logic [63:0] rr(input logic [63:0] v, input int n);
    return 64'({v, v} >> n);
  endfunction

  function automatic logic [319:0] ref_init(input logic [127:0] k, input logic [127:0] n);
    logic [63:0] x [5];
    logic [63:0] t [5];
    logic [4:0]  c;
    x[0] = 64'h80400c0600000000;
    x[1] = k[127:64]; x[2] = k[63:0];
    x[3] = n[127:64]; x[4] = n[63:0];
    for (int r = 12 - R; r < 12; r++) begin
      x[2] ^= 64'(240 - 15 * r);
      for (int i = 0; i < 64; i++) begin
        c = SB[{x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]}];
        for (int j = 0; j < 5; j++) t[j][i] = c[4-j];
      end
      x[0] = t[0] ^ rr(t[0], 19) ^ rr(t[0], 28);
      x[1] = t[1] ^ rr(t[1], 61) ^ rr(t[1], 39);
      x[2] = t[2] ^ rr(t[2], 1)  ^ rr(t[2], 6);
      x[3] = t[3] ^ rr(t[3], 10) ^ rr(t[3], 17);
      x[4] = t[4] ^ rr(t[4], 7)  ^ rr(t[4], 41);
    end
    x[3] ^= k[127:64];
    x[4] ^= k[63:0];
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // reference: countdown of edges left in the current operation
  always @(posedge clk) begin
    rst_edge = rst;
    if (rst) begin
      rem = 0;
      exp_done = 0;
      exp_q.delete();
    end else begin
      exp_done = (rem == 1);
      if (rem > 0) rem--;
      if (bus.start && rem == 0) begin
        exp_q.push_back(ref_init(bus.key, bus.nonce));
        rem = R;
      end
    end
    exp_busy = rem > 0;
  end

  always @(negedge clk) begin
    if (rst_edge) last_sout = '0;
    chk(bus.busy == exp_busy, "busy", 320'(bus.busy), 320'(exp_busy));
    chk(bus.done == exp_done, "done", 320'(bus.done), 320'(exp_done));
    if (bus.done) begin
      if (exp_q.size() == 0) chk(1'b0, "unexpected_done", 320'(1), 320'(0));
      else last_sout = exp_q.pop_front();
    end
    chk(bus.ini_sout == last_sout, "ini_sout", bus.ini_sout, last_sout);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    bus.start = 0;
    bus.key   = '0;
    bus.nonce = '0;
    cyc(2);
    rst = 0;
    cyc(20);
    bus.key   = 128'h000102030405060708090a0b0c0d0e0f;
    bus.nonce = 128'h000102030405060708090a0b0c0d0e0f;
    bus.start = 1;
    cyc(1);
    bus.start = 0;
    repeat (14) begin
      bus.key = r128();
      bus.nonce = r128();
      cyc(1);
    end
    bus.start = 1;
    cyc(1);
    bus.start = 0;
    cyc(4);
    bus.nonce = r128();
    bus.start = 1;
    cyc(1);
    bus.start = 0;
    cyc(10);
    bus.key = r128();
    bus.start = 1;
    repeat (30) begin
      bus.nonce = r128();
      cyc(1);
    end
    bus.start = 0;
    cyc(14);
    bus.start = 1;
    cyc(1);
    bus.start = 0;
    cyc(6);
    rst = 1;
    cyc(1);
    rst = 0;
    cyc(3);
    bus.key = r128();
    bus.nonce = r128();
    bus.start = 1;
    cyc(1);
    bus.start = 0;
    cyc(14);
    repeat (300) begin
      bus.start = ($urandom_range(3) == 0);
      bus.key   = r128();
      bus.nonce = r128();
      rst       = ($urandom_range(99) == 0);
      cyc(1);
    end
    rst = 0;
    bus.start = 0;
    cyc(16);
    chk(exp_q.size() == 0, "pending_results", 320'(exp_q.size()), 320'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
